// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Serial two-channel TDM demultiplexer. Each frame is 2*WORD consecutive
//   bits on i_din. The first bit is marked by i_sync. Even frame bits belong to
//   channel A and odd frame bits belong to channel B. Both channels are sent
//   MSB first and interleaved A,B,A,B.
//
// Ports
//   i_clk          single clock, rising edge
//   i_rst          synchronous active-high reset
//   i_din          serial multiplexed data, sampled every rising edge
//   i_sync         frame start marker; the i_din bit of the same cycle is bit 0
//   o_a_word       last complete channel-A word
//   o_b_word       last complete channel-B word
//   o_frame_valid  one-cycle pulse when o_a_word/o_b_word update
//   o_busy         high while a frame is partially received
//   o_sync_err     one-cycle pulse when a sync arrives in the middle of a frame
// ---------------------------------------------------------------------------
module tdm_demux #(
  parameter int WORD = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_din,
  input  logic            i_sync,
  output logic [WORD-1:0] o_a_word,
  output logic [WORD-1:0] o_b_word,
  output logic            o_frame_valid,
  output logic            o_busy,
  output logic            o_sync_err
);

  localparam int CW = $clog2(2 * WORD);
  localparam logic [CW-1:0] LAST = CW'(2 * WORD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_next_cnt;
  logic [WORD-1:0] r_a_sh;
  logic [WORD-1:0] r_b_sh;
  logic [WORD-1:0] w_next_a_sh;
  logic [WORD-1:0] w_next_b_sh;
  logic            w_done;
  logic            w_sync_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath decisions. A sync always restarts the frame with
  // the current i_din as bit 0. It is an error only when a frame was already
  // in progress. The cycle right after the last bit is IDLE again, so a
  // back-to-back sync there is a clean start.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_a_sh  = r_a_sh;
    w_next_b_sh  = r_b_sh;
    w_done       = 1'b0;
    w_sync_err   = 1'b0;

    if (i_sync) begin
      w_sync_err   = (r_state == RECV);
      w_next_state = RECV;
      w_next_cnt   = CW'(1);
      w_next_a_sh  = {{(WORD-1){1'b0}}, i_din};
      w_next_b_sh  = '0;
    end else if (r_state == RECV) begin
      // Bit 0 of the counter selects the channel: even bits go to A and odd bits go to B.
      if (!r_cnt[0]) begin
        w_next_a_sh = {r_a_sh[WORD-2:0], i_din};
      end else begin
        w_next_b_sh = {r_b_sh[WORD-2:0], i_din};
      end

      if (r_cnt == LAST) begin
        w_done       = 1'b1;
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end else begin
        w_next_cnt = r_cnt + CW'(1);
      end
    end
  end

  // Datapath registers. On the last bit the output words are loaded from the
  // next shift-register values, which already include that final bit. This
  // makes frame_valid appear in the cycle after the last bit is sampled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_a_sh        <= '0;
      r_b_sh        <= '0;
      o_a_word      <= '0;
      o_b_word      <= '0;
      o_frame_valid <= 1'b0;
      o_sync_err    <= 1'b0;
    end else begin
      r_cnt         <= w_next_cnt;
      r_a_sh        <= w_next_a_sh;
      r_b_sh        <= w_next_b_sh;
      o_frame_valid <= w_done;
      o_sync_err    <= w_sync_err;
      if (w_done) begin
        o_a_word <= w_next_a_sh;
        o_b_word <= w_next_b_sh;
      end
    end
  end

  assign o_busy = (r_state == RECV);

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter WORD, default 8, SHALL set the bits per channel word; legal range is 2 to 16.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 din  in  1  SHALL carry the serial multiplexed line, sampled on every rising clk edge.
REQ-005 sync  in  1  SHALL mark a frame start when high; the din bit sampled in the same cycle is frame bit 0.
REQ-006 a_word  out  WORD  SHALL hold the last complete channel-A word.
REQ-007 b_word  out  WORD  SHALL hold the last complete channel-B word.
REQ-008 frame_valid  out  1  SHALL pulse for one cycle when a_word and b_word update.
REQ-009 busy  out  1  SHALL be high while a frame is partially received.
REQ-010 sync_err  out  1  SHALL pulse for one cycle when sync arrives mid-frame.

Function
REQ-011 Frame format SHALL be 2*WORD consecutive din bits.
REQ-012 Bit 2k SHALL map to a_word[WORD-1-k], and bit 2k+1 SHALL map to b_word[WORD-1-k]; channels interleave A,B,A,B and are MSB first.
REQ-013 The FSM SHALL have exactly two states, IDLE and RECV.
REQ-014 In IDLE with sync=1, the block SHALL capture din as bit 0, set bit counter to 1, and go to RECV; with sync=0 it stays in IDLE and din is ignored.
REQ-015 In RECV with sync=0, the block SHALL capture din as the bit indexed by the counter and increment the counter.
REQ-016 When bit 2*WORD-1 is captured, the block SHALL load both channel shift registers into a_word/b_word on the next edge, pulse frame_valid in that cycle, and return to IDLE.
REQ-017 Latency SHALL be exactly 1 cycle from the sampling edge of the last frame bit to frame_valid=1.
REQ-018 In RECV with sync=1, the block SHALL discard the partial frame, pulse sync_err, and restart with din as bit 0; the counter is set to 1 and the state stays RECV.
REQ-019 Sync in the cycle immediately after the last frame bit is a back-to-back frame start; it SHALL NOT raise sync_err and SHALL start a new frame while frame_valid pulses.
REQ-020 Sync held high across multiple cycles SHALL restart the frame every cycle and raise sync_err on every cycle after the first.
REQ-021 a_word and b_word SHALL hold their values between frame_valid pulses; partial or aborted frames never change them.
REQ-022 busy SHALL equal 1 exactly when the state is RECV.
REQ-023 The bit counter SHALL be sized ceil(log2(2*WORD)) bits and never wraps; completion returns it to 0.

Reset
REQ-024 While rst=1, the block SHALL set state to IDLE, the counter to 0, and the shift registers, a_word, b_word, frame_valid, busy and sync_err to 0.
REQ-025 rst SHALL take precedence over sync and din in the same cycle.
REQ-026 rst asserted mid-frame SHALL discard the frame with no frame_valid pulse.
REQ-027 The first frame after reset SHALL require a fresh sync.

Verification (WORD=8)
REQ-028 Reset, then one frame with A=0xA5, B=0x3C; bit 0 is sent with sync -> frame_valid pulses 1 cycle after bit 15, a_word=0xA5, b_word=0x3C, sync_err never asserts.
REQ-029 Frame A=0xFF/B=0x00, then immediately A=0x00/B=0xFF back-to-back -> two frame_valid pulses 16 cycles apart, no sync_err, final a_word=0x00 and b_word=0xFF.
REQ-030 Sync reasserted at bit 6, then a full frame A=0x12/B=0x34 -> sync_err pulses once, a single frame_valid occurs, a_word=0x12 and b_word=0x34, and the previous outputs are unchanged until then.
REQ-031 rst=1 for 1 cycle at bit 9 of a frame -> busy=0 next cycle, no frame_valid, outputs remain 0x00; a subsequent full frame 0x5A/0xC3 decodes correctly.
REQ-032 din toggling with sync=0 for 40 cycles after reset -> busy, frame_valid and sync_err stay 0, and a_word and b_word stay 0x00.
REQ-033 rst=1 and sync=1 in the same cycle -> the block stays in IDLE with busy=0, and the next frame requires a new sync.
